// File: rtl/darkfetch.sv
// Instruction prefetch unit: issues pipelined darkbus word reads, buffers the
// returned words with their addresses in a small FIFO, and serves the core.
module darkfetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        XCLK,
  input  logic        XRES,
  output logic [31:0] BUS_ADDR,
  output logic        BUS_RW,
  output logic        BUS_EN,
  input  logic [31:0] BUS_DATA,
  input  logic        BUS_VALID,
  input  logic        FETCH_EN,
  input  logic        REDIR,
  input  logic [31:0] REDIR_PC,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_V,
  input  logic        INSTR_RDY
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic          issued_q, issued_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          issue;
  logic          cap;
  logic          pop;
  logic [AW+1:0] inflight;
  logic          unused_redir_bits;

  assign unused_redir_bits = ^REDIR_PC[1:0];

  // Occupancy uses the registered count, so a same-cycle pop never makes room
  // for a new request; the outstanding request reserves its slot.
  always_comb begin
    inflight = {1'b0, count_q} + (AW+2)'(issued_q);
    issue    = !XRES && FETCH_EN && !REDIR && (inflight < (AW+2)'(DEPTH));
    cap      = issued_q && BUS_VALID && !REDIR;
    pop      = (count_q != '0) && INSTR_RDY && !REDIR;
  end

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    issued_d = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (REDIR) begin
      pc_d     = {REDIR_PC[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        rsp_pc_d = pc_q;
        issued_d = 1'b1;
      end
      if (cap) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({cap, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      pc_q     <= PC_INIT;
      rsp_pc_q <= PC_INIT;
      issued_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      issued_q <= issued_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head is only meaningful while INSTR_V is high.
  always_ff @(posedge XCLK) begin
    if (cap) begin
      mem_data_q[wr_ptr_q] <= BUS_DATA;
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  // en stays high in the response cycle so the responder keeps driving data.
  assign BUS_ADDR = pc_q;
  assign BUS_RW   = 1'b0;
  assign BUS_EN   = issue || issued_q;
  assign INSTR_V  = (count_q != '0);
  assign INSTR    = mem_data_q[rd_ptr_q];
  assign INSTR_PC = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_darkfetch.sv
// Scoreboard bench for darkfetch: a ROM responder model answers one cycle
// after en, a monitor pops expected {pc, data} entries at every handshake.
module tb_darkfetch;

  logic        XCLK = 1'b0;
  logic        XRES;
  logic [31:0] BUS_ADDR;
  logic        BUS_RW;
  logic        BUS_EN;
  logic [31:0] BUS_DATA;
  logic        BUS_VALID;
  logic        FETCH_EN;
  logic        REDIR;
  logic [31:0] REDIR_PC;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_V;
  logic        INSTR_RDY;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  darkfetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .XCLK      (XCLK),
    .XRES      (XRES),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_RW    (BUS_RW),
    .BUS_EN    (BUS_EN),
    .BUS_DATA  (BUS_DATA),
    .BUS_VALID (BUS_VALID),
    .FETCH_EN  (FETCH_EN),
    .REDIR     (REDIR),
    .REDIR_PC  (REDIR_PC),
    .INSTR     (INSTR),
    .INSTR_PC  (INSTR_PC),
    .INSTR_V   (INSTR_V),
    .INSTR_RDY (INSTR_RDY)
  );

  initial forever #5 XCLK = ~XCLK;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = rom(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    INSTR_RDY = 1'b0;
  endtask

  // ROM responder: samples the request before the edge, answers after it.
  initial begin
    logic        v;
    logic [31:0] a;
    BUS_VALID = 1'b0;
    BUS_DATA  = 32'h0;
    forever begin
      @(negedge XCLK);
      v = BUS_EN;
      a = BUS_ADDR;
      @(posedge XCLK);
      #1;
      BUS_VALID = v;
      BUS_DATA  = v ? rom(a) : 32'h0;
    end
  end

  // Monitor: a handshake seen before the edge consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge XCLK);
      if (!XRES && INSTR_V && INSTR_RDY && !REDIR) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: actual pc %h required none", INSTR_PC);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", INSTR_PC, e.pc);
          chk("instr_data", INSTR, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    XRES      = 1'b1;
    FETCH_EN  = 1'b1;
    REDIR     = 1'b0;
    REDIR_PC  = 32'h0;
    INSTR_RDY = 1'b1;
    repeat (3) @(posedge XCLK);
    @(negedge XCLK);
    chk("rst_instr_v", 32'(INSTR_V), 32'd0);
    chk("rst_bus_en", 32'(BUS_EN), 32'd0);
    chk("rst_bus_addr", BUS_ADDR, 32'h0);
    chk("rst_bus_rw", 32'(BUS_RW), 32'd0);

    // Reset fetch: first word 2 cycles after release, then one per cycle.
    tick();
    for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
    XRES = 1'b0;
    @(negedge XCLK);
    chk("first_v_c0", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("first_v_c1", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("first_v_c2", 32'(INSTR_V), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      @(negedge XCLK);
      chk("no_gap_v", 32'(INSTR_V), 32'd1);
    end
    tick();
    INSTR_RDY = 1'b0;
    chk("reset_fetch_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: FIFO fills with 0..12 and the bus goes idle.
    REDIR    = 1'b1;
    REDIR_PC = 32'h0;
    tick();
    REDIR = 1'b0;
    repeat (9) tick();
    @(negedge XCLK);
    chk("full_bus_en", 32'(BUS_EN), 32'd0);
    chk("full_instr_v", 32'(INSTR_V), 32'd1);
    chk("full_bus_addr", BUS_ADDR, 32'd16);
    chk("full_head_pc", INSTR_PC, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
    INSTR_RDY = 1'b1;
    drain("backpressure_left");

    // Redirect in the cycle the response for address 8 arrives.
    REDIR     = 1'b1;
    REDIR_PC  = 32'h0;
    INSTR_RDY = 1'b1;
    expect_pc(32'h0);
    tick();
    REDIR = 1'b0;
    tick();
    tick();
    tick();
    REDIR    = 1'b1;
    REDIR_PC = 32'h0000_0102;
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    tick();
    REDIR = 1'b0;
    @(negedge XCLK);
    chk("redir_v_r1", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("redir_v_r2", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("redir_v_r3", 32'(INSTR_V), 32'd1);
    drain("redirect_left");

    // FETCH_EN drops one cycle after an issue.
    REDIR     = 1'b1;
    REDIR_PC  = 32'h200;
    INSTR_RDY = 1'b1;
    expect_pc(32'h200);
    tick();
    REDIR = 1'b0;
    tick();
    FETCH_EN = 1'b0;
    @(negedge XCLK);
    chk("fen_rsp_en", 32'(BUS_EN), 32'd1);
    tick();
    @(negedge XCLK);
    chk("fen_en_low", 32'(BUS_EN), 32'd0);
    chk("fen_addr", BUS_ADDR, 32'h204);
    tick();
    @(negedge XCLK);
    chk("fen_en_idle", 32'(BUS_EN), 32'd0);
    chk("fen_v_idle", 32'(INSTR_V), 32'd0);
    tick();
    FETCH_EN = 1'b1;
    expect_pc(32'h204);
    expect_pc(32'h208);
    drain("fetch_en_left");

    // Asynchronous reset while three entries are buffered.
    REDIR    = 1'b1;
    REDIR_PC = 32'h300;
    tick();
    REDIR = 1'b0;
    repeat (4) tick();
    chk("pre_rst_v", 32'(INSTR_V), 32'd1);
    chk("pre_rst_en", 32'(BUS_EN), 32'd1);
    #2;
    XRES = 1'b1;
    #1;
    chk("async_rst_v", 32'(INSTR_V), 32'd0);
    chk("async_rst_en", 32'(BUS_EN), 32'd0);
    chk("async_rst_addr", BUS_ADDR, 32'h0);
    tick();
    tick();
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    INSTR_RDY = 1'b1;
    XRES      = 1'b0;
    @(negedge XCLK);
    chk("rerst_v_c0", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("rerst_v_c1", 32'(INSTR_V), 32'd0);
    tick();
    @(negedge XCLK);
    chk("rerst_v_c2", 32'(INSTR_V), 32'd1);
    drain("rerst_left");

    // pc wraps past the top of the address space.
    REDIR     = 1'b1;
    REDIR_PC  = 32'hFFFF_FFF8;
    INSTR_RDY = 1'b1;
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    expect_pc(32'h0000_0004);
    tick();
    REDIR = 1'b0;
    drain("wrap_left");

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
